// File: rtl/ram_arb_pkg.sv
// Shared widths and encodings for the RAM port arbiter and its round-robin selector.
package ram_arb_pkg;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Width of an index into n items; never below one bit so ports stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Single_port_ram.sv
// Single-port RAM with registered read; data_out clears on synchronous active-low reset.
module Single_port_ram
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_LENGTH = 64,
    parameter int unsigned AW         = idx_width(MEM_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [AW-1:0]         write_address,
    input  logic [AW-1:0]         read_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];
    logic [DATA_WIDTH-1:0] data_out_d, data_out_q;

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_address] <= data_in;
        end
    end

    always_comb begin
        data_out_d = rst ? mem[read_address] : '0;
    end

    always_ff @(posedge clk) begin
        data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid bit at or after ptr_i, wrapping.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = (int'(ptr_i) + k) % int'(NUM_REQ);
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port RAM among NUM_REQ valid/ready requesters;
// read data returns one cycle after acceptance with a one-hot owner strobe.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_LENGTH = 64,
    parameter int unsigned NUM_REQ    = 4,
    localparam int unsigned AW        = idx_width(MEM_LENGTH),
    localparam int unsigned IW        = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data
);

    logic [IW-1:0]         ptr_d, ptr_q;
    logic                  rd_pend_d, rd_pend_q;
    logic [IW-1:0]         rd_tag_d, rd_tag_q;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  xfer;
    logic                  sel_we;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        // Reset masks the grant so nothing transfers and the RAM never writes.
        xfer      = pick_any & rst;
        req_ready = rst ? pick_grant : '0;
        sel_we    = req_we[pick_idx];
        ram_addr  = req_addr[pick_idx*AW +: AW];
        ram_wdata = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        ram_we    = xfer & (sel_we == WR);

        ptr_d     = ptr_q;
        rd_tag_d  = rd_tag_q;
        rd_pend_d = xfer & (sel_we == RD);
        if (xfer) begin
            ptr_d    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
            rd_tag_d = pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    // Gated by rst so a response pending when reset arrives never appears.
    always_comb begin
        rsp_valid           = '0;
        rsp_valid[rd_tag_q] = rd_pend_q & rst;
    end

    Single_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_LENGTH (MEM_LENGTH),
        .AW         (AW)
    ) u_ram (
        .clk           (clk),
        .rst           (rst),
        .write_en      (ram_we),
        .write_address (ram_addr),
        .read_address  (ram_addr),
        .data_in       (ram_wdata),
        .data_out      (rsp_data)
    );

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one single-port RAM between NUM_REQ independent requesters, each issuing reads and writes through a valid/ready handshake. It sits between client engines and the team's `Single_port_ram` instance, which it owns. It drives the RAM's write_address and read_address from the same granted address, so exactly one access is issued per cycle. Read data returns one cycle after acceptance, tagged to the originating requester.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- MEM_LENGTH, 64, RAM depth in words; AW = $clog2(MEM_LENGTH)
- NUM_REQ, 4, number of requesters (≥2); IW = $clog2(NUM_REQ)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  per-requester write (1) / read (0)
- req_addr  in  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant; at most one bit set
- rsp_valid  out  NUM_REQ  one-hot read-response strobe
- rsp_data  out  DATA_WIDTH  shared read-data bus, valid where rsp_valid≠0

## Operation
- Transfer for requester i occurs when req_valid[i] & req_ready[i]. A requester holds valid, we, addr and wdata stable until accepted.
- Grant is combinational from req_valid and the priority pointer `ptr` (IW bits). Search order is ptr, ptr+1, …, wrapping at NUM_REQ-1→0. The first valid requester is granted.
- On a transfer to requester g, `ptr` is set to g+1 modulo NUM_REQ at the clock edge. With no transfer, `ptr` holds.
- RAM drive in the grant cycle:
  - write_en = granted & req_we[g]
  - write_address = read_address = req_addr[g]
  - data_in = req_wdata[g]
  - With no grant, write_en = 0 and the address is don't-care.
- Read transfer:
  - Registers rd_pend = 1 and rd_tag = g.
  - Next cycle, rsp_valid = onehot(rd_tag) when rd_pend, and rsp_data = RAM data_out.
- Write transfer:
  - Produces no response.
  - Data is visible to any read accepted in a later cycle.
- Reads and writes from different requesters are accepted back-to-back at one per cycle. There are no bubbles.
- Reads of never-written locations return undefined data. This is not checked.

## Timing
- Reset (rst=0 at an edge):
  - ptr = 0, rd_pend = 0, rsp_valid = 0.
  - req_ready = 0 while rst=0, with write_en forced 0.
  - rsp_data = 0, because the RAM clears data_out.
- Latency: read accepted in cycle N gives rsp_valid/rsp_data in cycle N+1 for exactly one cycle. A write accepted in cycle N commits at the end of N.
- Throughput: one transfer per cycle total, shared across requesters.
- Combinational path req_valid → req_ready exists. Requesters must not make req_valid depend on req_ready.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Boundary conditions:
  - Single active requester: granted every cycle; ptr cycles back to it each transfer.
  - All requesters valid: grants rotate 0,1,2,…,NUM_REQ-1,0.
  - ptr wraps to 0 after granting NUM_REQ-1.
  - Write then read of the same address in consecutive cycles: the read returns the new data.
  - Reset asserted the cycle after a read acceptance: the response is suppressed (rsp_valid = 0) and nothing is lost-tracked.
  - Request deasserted before grant: allowed; no state change.

## Structure
- Shared package ram_arb_pkg:
  - function for clog2-based widths (AW, IW)
  - localparam RD = 1'b0 and WR = 1'b1 for req_we encoding
- Single sub-module `rr_pick`: combinational round-robin selector (valid vector, ptr → one-hot grant and index). It is reusable by other arbiters.
- Top instantiates `rr_pick`, the ptr/rd_pend/rd_tag registers, the request mux and `Single_port_ram`.

## Test plan
- Reset and idle:
  - Hold rst=0 for 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, rsp_data=0.
  - After release, first grant goes to requester 0.
- Write/read single requester: req 1 writes 8'hA5 to addr 5, then reads addr 5 → rsp_valid=4'b0010 with rsp_data=8'hA5 one cycle after the read grant.
- Round-robin rotation:
  - All 4 requesters read continuously → grants follow 0,1,2,3,0,1.
  - Each rsp_valid appears one cycle after the matching grant.
- Pointer skip: ptr=2 (after granting 1), only requesters 0 and 3 valid → grant 3, then 0.
- Back-to-back hazard: req 0 writes 8'h3C to addr 63 in cycle N; req 2 reads addr 63 in N+1 → rsp_data=8'h3C, rsp_valid=4'b0100 in N+2.
- Reset mid-operation: read accepted in cycle N, rst=0 at the N+1 edge → no rsp_valid pulse, ptr=0 after release.
